// File: rtl/reg_read_arbiter.sv
// Read-port arbiter for a single-ported register file.
// Serves a two-operand fetch path and a single-read display path.
module reg_read_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_req,
    input  logic [ADDR_W-1:0] op_addr_a,
    input  logic [ADDR_W-1:0] op_addr_b,
    output logic              op_gnt,
    output logic              op_valid,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              op_ack,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    output logic              rf_ren,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        OP_RDA,
        OP_RDB,
        OP_CAPB,
        OP_HOLD,
        DISP_RD,
        DISP_CAP
    } state_t;

    state_t            state;
    logic              last_disp;
    logic [ADDR_W-1:0] addr_b;

    // Grant decision: only in IDLE, alternating on ties.
    always_comb begin
        op_gnt   = 1'b0;
        disp_gnt = 1'b0;
        if (!rst && state == IDLE) begin
            if (op_req && (!disp_req || last_disp)) begin
                op_gnt = 1'b1;
            end else if (disp_req) begin
                disp_gnt = 1'b1;
            end
        end
    end

    // Sequencer: issues reads and captures the returned data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_disp  <= 1'b1;
            addr_b     <= '0;
            op_valid   <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
            rf_ren     <= 1'b0;
            rf_addr    <= '0;
        end else begin
            disp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_gnt) begin
                        state     <= OP_RDA;
                        last_disp <= 1'b0;
                        rf_ren    <= 1'b1;
                        rf_addr   <= op_addr_a;
                        addr_b    <= op_addr_b;
                    end else if (disp_gnt) begin
                        state     <= DISP_RD;
                        last_disp <= 1'b1;
                        rf_ren    <= 1'b1;
                        rf_addr   <= disp_addr;
                    end
                end
                OP_RDA: begin
                    state   <= OP_RDB;
                    rf_addr <= addr_b;
                end
                OP_RDB: begin
                    state   <= OP_CAPB;
                    op_a    <= rf_rdata;
                    rf_ren  <= 1'b0;
                    rf_addr <= '0;
                end
                OP_CAPB: begin
                    state    <= OP_HOLD;
                    op_b     <= rf_rdata;
                    op_valid <= 1'b1;
                end
                OP_HOLD: begin
                    if (op_ack) begin
                        state    <= IDLE;
                        op_valid <= 1'b0;
                    end
                end
                DISP_RD: begin
                    state   <= DISP_CAP;
                    rf_ren  <= 1'b0;
                    rf_addr <= '0;
                end
                DISP_CAP: begin
                    state      <= IDLE;
                    disp_data  <= rf_rdata;
                    disp_valid <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    rf_ren  <= 1'b0;
                    rf_addr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_read_arbiter.sv
// Bench for reg_read_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_reg_read_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_req, op_ack, disp_req;
    logic [2:0] op_addr_a, op_addr_b, disp_addr;
    logic       op_gnt, op_valid, disp_gnt, disp_valid, rf_ren;
    logic [7:0] op_a, op_b, disp_data, rf_rdata;
    logic [2:0] rf_addr;

    logic [7:0] mem [8];

    int npass = 0;
    int ntot  = 0;
    bit run   = 0;
    bit rnd   = 0;
    bit seen_op, seen_disp;

    // model state
    int  c = 0;
    int  kind = 0;
    int  t0 = -100;
    int  t0d = -100;
    int  dd_cyc = -100;
    bit  last_op = 0;
    logic [2:0] pa, pb, pd;
    logic [7:0] exp_opa = 0, exp_opb = 0, exp_dd = 0;

    reg_read_arbiter dut (
        .clk(clk), .rst(rst),
        .op_req(op_req), .op_addr_a(op_addr_a), .op_addr_b(op_addr_b),
        .op_gnt(op_gnt), .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
        .op_ack(op_ack),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_valid(disp_valid), .disp_data(disp_data),
        .rf_ren(rf_ren), .rf_addr(rf_addr), .rf_rdata(rf_rdata)
    );

    always #5 clk = ~clk;

    // register file: data one cycle after a read, junk otherwise
    always @(posedge clk)
        rf_rdata <= rf_ren ? mem[rf_addr] : 8'($urandom);

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, c);
    endtask

    // per-cycle reference model and comparison
    always @(negedge clk) begin
        bit eo, ed, ren;
        int k;
        logic [2:0] ad;
        seen_op   = op_gnt;
        seen_disp = disp_gnt;
        if (run) begin
            k  = c - t0;
            eo = !rst && kind == 0 && op_req && (!disp_req || !last_op);
            ed = !rst && kind == 0 && disp_req && !eo;
            ren = (kind == 1 && (k == 1 || k == 2)) || (kind == 2 && k == 1);
            ad = 3'd0;
            if (kind == 1 && k == 1) ad = pa;
            if (kind == 1 && k == 2) ad = pb;
            if (kind == 2 && k == 1) ad = pd;
            chk("op_gnt", op_gnt, eo);
            chk("disp_gnt", disp_gnt, ed);
            chk("rf_ren", rf_ren, ren);
            chk("rf_addr", rf_addr, ad);
            chk("op_valid", op_valid, kind == 1 && k >= 4);
            if (!(kind == 1 && k < 4)) begin
                chk("op_a", op_a, exp_opa);
                chk("op_b", op_b, exp_opb);
            end
            chk("disp_valid", disp_valid, c == dd_cyc);
            if (!(c > t0d && c < dd_cyc))
                chk("disp_data", disp_data, exp_dd);
            if (rst) begin
                kind = 0; t0 = -100; t0d = -100; dd_cyc = -100;
                last_op = 0; exp_opa = 0; exp_opb = 0; exp_dd = 0;
            end else if (eo) begin
                kind = 1; t0 = c; pa = op_addr_a; pb = op_addr_b;
                exp_opa = mem[pa]; exp_opb = mem[pb]; last_op = 1;
            end else if (ed) begin
                kind = 2; t0 = c; t0d = c; dd_cyc = c + 3;
                pd = disp_addr; exp_dd = mem[pd]; last_op = 0;
            end else if (kind == 1 && k >= 4 && op_ack) begin
                kind = 0;
            end else if (kind == 2 && k == 2) begin
                kind = 0;
            end
            c++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (seen_op) op_req = 0;
        if (seen_disp) disp_req = 0;
        if (rnd) begin
            rst = ($urandom_range(0, 149) == 0);
            op_ack = ($urandom_range(0, 2) == 0);
            if (!op_req && !seen_op && $urandom_range(0, 3) == 0) begin
                op_req = 1;
                op_addr_a = 3'($urandom);
                op_addr_b = 3'($urandom);
            end
            if (!disp_req && !seen_disp && $urandom_range(0, 3) == 0) begin
                disp_req = 1;
                disp_addr = 3'($urandom);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1; op_req = 0; disp_req = 0; op_ack = 0;
        step();
        step();
        rst = 0;
    endtask

    task automatic wait_op_valid(string tag);
        for (int i = 0; i < 30 && !op_valid; i++) step();
        chk(tag, op_valid, 1);
    endtask

    task automatic wait_disp_valid(string tag);
        for (int i = 0; i < 40 && !disp_valid; i++) step();
        chk(tag, disp_valid, 1);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
        rst = 1; op_req = 0; disp_req = 0; op_ack = 0;
        op_addr_a = 0; op_addr_b = 0; disp_addr = 0;
        step();
        step();
        run = 1;
        step();
        chk("rst_op_valid", op_valid, 0);
        chk("rst_rf_addr", rf_addr, 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_disp_data", disp_data, 0);
        rst = 0;

        // single op fetch A=2 B=5
        op_req = 1; op_addr_a = 2; op_addr_b = 5;
        #1 chk("op_gnt_T", op_gnt, 1);
        wait_op_valid("wait_op1");
        chk("op_a_12", op_a, 8'h12);
        chk("op_b_15", op_b, 8'h15);
        op_ack = 1;
        step();
        op_ack = 0;

        // tie after reset, same-address op, delayed ack
        do_reset();
        op_req = 1; op_addr_a = 1; op_addr_b = 1;
        disp_req = 1; disp_addr = 3;
        #1 chk("tie1_op", op_gnt, 1);
        wait_op_valid("wait_op2");
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_valid", op_valid, 1);
            chk("hold_a", op_a, 8'h11);
            chk("hold_b", op_b, 8'h11);
            chk("hold_no_dgnt", disp_gnt, 0);
        end
        op_ack = 1;
        step();
        op_ack = 0;
        #1 chk("disp_after_ack", disp_gnt, 1);
        wait_disp_valid("wait_disp1");
        chk("disp_13", disp_data, 8'h13);
        op_req = 1; op_addr_a = 4; op_addr_b = 6;
        disp_req = 1; disp_addr = 0;
        #1 chk("tie2_op", op_gnt, 1);
        wait_op_valid("wait_op3");
        op_ack = 1;
        step();
        op_ack = 0;
        wait_disp_valid("wait_disp2");
        step();

        // display read of register 7
        do_reset();
        disp_req = 1; disp_addr = 7;
        #1 chk("disp_gnt_T", disp_gnt, 1);
        wait_disp_valid("wait_disp3");
        chk("disp_17", disp_data, 8'h17);
        step();
        chk("disp_pulse", disp_valid, 0);
        chk("disp_hold", disp_data, 8'h17);

        // reset during OP_RDB
        do_reset();
        op_req = 1; op_addr_a = 3; op_addr_b = 4;
        step();
        step();
        rst = 1;
        step();
        rst = 0;
        chk("rst_rdb_ren", rf_ren, 0);
        chk("rst_rdb_state", dut.state, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("no_op_valid", op_valid, 0);
        end

        // random traffic with random register contents
        do_reset();
        for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
        rnd = 1;
        for (int i = 0; i < 3000; i++) step();
        rnd = 0;
        rst = 0; op_req = 0; disp_req = 0; op_ack = 1;
        for (int i = 0; i < 10; i++) step();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/reg_read_arbiter.md
REG_READ_ARBITER -- requirements
Module: reg_read_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, register-file word width.
REQ-002 Parameter ADDR_W, default 3, register-file address width (8 entries).
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 op_req  in  1  operand-fetch request from execute unit (level).
REQ-006 op_addr_a  in  ADDR_W  operand A register index, sampled at grant.
REQ-007 op_addr_b  in  ADDR_W  operand B register index, sampled at grant.
REQ-008 op_gnt  out  1  one-cycle pulse: op request accepted.
REQ-009 op_valid  out  1  op_a/op_b valid; held until op_ack.
REQ-010 op_a  out  DATA_W  captured operand A.
REQ-011 op_b  out  DATA_W  captured operand B.
REQ-012 op_ack  in  1  execute unit consumed operands.
REQ-013 disp_req  in  1  single-read request from display path (level).
REQ-014 disp_addr  in  ADDR_W  display register index, sampled at grant.
REQ-015 disp_gnt  out  1  one-cycle pulse: display request accepted.
REQ-016 disp_valid  out  1  one-cycle pulse: disp_data updated.
REQ-017 disp_data  out  DATA_W  last display read value, held between updates.
REQ-018 rf_ren  out  1  register-file read enable.
REQ-019 rf_addr  out  ADDR_W  register-file read address; 0 when rf_ren low.
REQ-020 rf_rdata  in  DATA_W  register-file data, valid exactly one cycle after rf_ren.

Function
REQ-021 FSM states SHALL be IDLE, OP_RDA, OP_RDB, OP_CAPB, OP_HOLD, DISP_RD, DISP_CAP.
REQ-022 Grants SHALL be issued only in IDLE; op_gnt/disp_gnt SHALL be mutually exclusive, asserted in the IDLE cycle where the request is accepted.
REQ-023 Only one request pending in IDLE: SHALL be granted in that cycle.
REQ-024 Both pending in IDLE: SHALL grant the requester not granted most recently (last_grant flag; updated on every grant).
REQ-025 Op grant at cycle T: addresses latched; OP_RDA at T+1 (rf_ren=1, rf_addr=A); OP_RDB at T+2 (rf_ren=1, rf_addr=B, op_a<=rf_rdata); OP_CAPB at T+3 (rf_ren=0, op_b<=rf_rdata); OP_HOLD from T+4 with op_valid=1.
REQ-026 OP_HOLD SHALL persist until op_ack=1, then return to IDLE next cycle with op_valid=0; op_a/op_b SHALL hold values until next capture.
REQ-027 op_ack while op_valid=0 SHALL be ignored.
REQ-028 Disp grant at cycle T: DISP_RD at T+1 (rf_ren=1, rf_addr=disp_addr latched); DISP_CAP at T+2 (disp_data<=rf_rdata, FSM->IDLE); disp_valid=1 for cycle T+3 only.
REQ-029 Requester SHALL drop req after its gnt; req still high in a later IDLE cycle SHALL count as a new request.
REQ-030 Requests arriving outside IDLE SHALL not be lost if held; none SHALL be granted until IDLE.
REQ-031 op_addr_a==op_addr_b SHALL be legal; both reads issued, op_a==op_b.
REQ-032 rf_ren SHALL be high only in OP_RDA, OP_RDB, DISP_RD; at most one read per cycle.

Reset
REQ-033 rst=1 at a clock edge SHALL force IDLE, last_grant=disp (op wins first tie), op_valid=0, disp_valid=0, op_gnt=0, disp_gnt=0, rf_ren=0, rf_addr=0, op_a=0, op_b=0, disp_data=0.
REQ-034 Reset mid-operation SHALL abandon the transaction; no op_valid/disp_valid SHALL follow from it.

Verification
REQ-035 RF holds reg[i]=8'h10+i; op_req, A=2, B=5 at T -> op_gnt@T, rf_addr 2@T+1, 5@T+2, op_valid@T+4 with op_a=8'h12, op_b=8'h15.
REQ-036 op_req and disp_req both high after reset -> op_gnt first; after op_ack, disp_gnt in next IDLE cycle; next tie goes to op.
REQ-037 disp_req addr=7 at T alone -> disp_gnt@T, rf_ren@T+1, disp_valid pulse@T+3 with disp_data=8'h17, held after.
REQ-038 op_ack withheld 10 cycles -> op_valid, op_a, op_b stable all 10 cycles; disp_req pending meanwhile granted only after return to IDLE.
REQ-039 rst asserted in OP_RDB -> next cycle IDLE, all outputs 0, no op_valid ever raised for that request.
